// File: rtl/lockstep_pkg.sv
// Shared types and sizing helpers for the lockstep comparison controller.
package lockstep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        FAULT  = 2'd3
    } lockstep_state_e;

    // Warmup counter must hold values up to DELAY.
    function automatic int unsigned warm_cnt_w(input int unsigned delay);
        return (delay < 1) ? 1 : $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// Aligning shift register: dout is din from DELAY cycles earlier.
module lockstep_delay_line #(
    parameter int unsigned LENGTH = 8,
    parameter int unsigned DELAY  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] din,
    output logic [LENGTH-1:0] dout
);

    logic [LENGTH-1:0] r_stage [DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < int'(DELAY); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DELAY-1];

endmodule

// File: rtl/lockstep_check_ctrl.sv
// Lockstep checker: aligns the reference stream, compares it against the lagging copy,
// counts mismatches and latches a sticky fault on a run of consecutive mismatches.
module lockstep_check_ctrl
    import lockstep_pkg::*;
#(
    parameter int unsigned LENGTH        = 8,
    parameter int unsigned DELAY         = 3,
    parameter int unsigned ERR_THRESHOLD = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic [LENGTH-1:0] signal_to_delay,
    input  logic [LENGTH-1:0] signal_delayed,
    output logic              equal,
    output logic              checking,
    output logic              error,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  mismatch_count
);

    localparam int unsigned WARM_W = warm_cnt_w(DELAY);
    localparam int unsigned CONS_W = $clog2(ERR_THRESHOLD + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(DELAY - 1);
    localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(ERR_THRESHOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    lockstep_state_e   r_state;
    logic [WARM_W-1:0] r_warm;
    logic [CONS_W-1:0] r_cons;
    logic [CNT_W-1:0]  r_cnt;
    logic [LENGTH-1:0] w_tail;
    logic              w_mismatch;

    lockstep_delay_line #(
        .LENGTH (LENGTH),
        .DELAY  (DELAY)
    ) u_delay_line (
        .clk  (clk),
        .rst  (rst),
        .din  (signal_to_delay),
        .dout (w_tail)
    );

    assign equal      = (w_tail == signal_delayed);
    assign w_mismatch = (r_state == CHECK) && !equal;

    // Sequencer and counters; clear is applied last so it overrides any increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_warm  <= '0;
            r_cons  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= WARMUP;
                        r_warm  <= '0;
                    end
                end
                WARMUP: begin
                    r_warm <= r_warm + 1'b1;
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (r_warm == WARM_LAST) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_cons  <= '0;
                    end else if (w_mismatch && !clear) begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_cons <= r_cons + 1'b1;
                        if (r_cons == CONS_LAST) begin
                            r_state <= FAULT;
                        end
                    end else begin
                        r_cons <= '0;
                    end
                end
                FAULT: begin
                    if (clear) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (clear) begin
                r_cnt  <= '0;
                r_cons <= '0;
            end
        end
    end

    assign state          = r_state;
    assign checking       = (r_state == CHECK);
    assign error          = (r_state == FAULT);
    assign mismatch_count = r_cnt;

endmodule
